// File: rtl/wos_window_sequencer.sv
// Window sequencer: streams each n x n window of an h x w image into the rank-order kernel and writes results back.
// Optional build macro WOS_ZERO_BORDER_EN: out-of-image pixels are delivered as zero instead of replicated border.
module wos_window_sequencer #(
    parameter int unsigned WORD   = 8,
    parameter int unsigned MAX_N  = 5,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  h,
    input  logic [DIM_W-1:0]  w,
    input  logic [DIM_W-1:0]  n,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              r_en,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [WORD-1:0]   r_data,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [WORD-1:0]   w_data,
    output logic              k_valid,
    output logic [WORD-1:0]   k_pixel,
    output logic              k_newline,
    input  logic              k_res_valid,
    input  logic [WORD-1:0]   k_res,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CW = DIM_W + 2;
    localparam int unsigned PW = 2 * DIM_W;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_SHIFT, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DIM_W-1:0]  h_q, w_q, n_q, h_d, w_d, n_d;
    logic [DIM_W-1:0]  row_q, col_q, dx_q, dy_q, row_d, col_d, dx_d, dy_d;
    logic [ADDR_W-1:0] src_q, dst_q, src_d, dst_d;
    logic              s1_v, s1_zero, s1_nl, s2_v, s2_zero, s2_nl;
    logic              issue, first_px, zero_px, bad, pipe_busy;
    logic              error_d, w_en_d;
    logic [ADDR_W-1:0] w_addr_d;
    logic [WORD-1:0]   w_data_d;
    logic [DIM_W-1:0]  half, last, y_c, x_c;
    logic signed [CW-1:0] y_s, x_s;
    logic [PW-1:0]     y_off, wr_off;
    logic [ADDR_W-1:0] rd_addr;

    // Window coordinate to clamped source address
    always_comb begin
        half    = n_q >> 1;
        last    = n_q - DIM_W'(1);
        y_s     = $signed({2'b00, row_q}) + $signed({2'b00, dy_q}) - $signed({2'b00, half});
        x_s     = $signed({2'b00, col_q}) + $signed({2'b00, dx_q}) - $signed({2'b00, half});
        y_c     = y_s[CW-1] ? '0 : ((y_s >= $signed({2'b00, h_q})) ? h_q - DIM_W'(1) : y_s[DIM_W-1:0]);
        x_c     = x_s[CW-1] ? '0 : ((x_s >= $signed({2'b00, w_q})) ? w_q - DIM_W'(1) : x_s[DIM_W-1:0]);
        y_off   = PW'(y_c) * PW'(w_q);
        wr_off  = PW'(row_q) * PW'(w_q);
        rd_addr = src_q + ADDR_W'(y_off) + ADDR_W'(x_c);
    end

`ifdef WOS_ZERO_BORDER_EN
    assign zero_px = y_s[CW-1] | x_s[CW-1]
                   | (y_s >= $signed({2'b00, h_q})) | (x_s >= $signed({2'b00, w_q}));
`else
    assign zero_px = 1'b0;
`endif

    assign bad       = ~n[0] | (n > DIM_W'(MAX_N)) | (h == '0) | (w == '0);
    assign pipe_busy = s1_v | s2_v | k_valid;

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        w_d      = w_q;
        n_d      = n_q;
        src_d    = src_q;
        dst_d    = dst_q;
        row_d    = row_q;
        col_d    = col_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        issue    = 1'b0;
        first_px = 1'b0;
        error_d  = error;
        w_en_d   = 1'b0;
        w_addr_d = w_addr;
        w_data_d = w_data;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    h_d   = h;
                    w_d   = w;
                    n_d   = n;
                    src_d = src_base;
                    dst_d = dst_base;
                    row_d = '0;
                    col_d = '0;
                    dx_d  = '0;
                    dy_d  = '0;
                    error_d = bad;
                    state_d = bad ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                issue    = 1'b1;
                first_px = (dx_q == '0) && (dy_q == '0);
                if (dy_q == last) begin
                    dy_d = '0;
                    if (dx_q == last) state_d = S_DRAIN;
                    else              dx_d = dx_q + DIM_W'(1);
                end else begin
                    dy_d = dy_q + DIM_W'(1);
                end
            end
            S_SHIFT: begin
                issue = 1'b1;
                if (dy_q == last) begin
                    dy_d    = '0;
                    state_d = S_DRAIN;
                end else begin
                    dy_d = dy_q + DIM_W'(1);
                end
            end
            S_DRAIN: begin
                // Results only count once the last pixel of the window has left the pipe
                if (k_res_valid && !pipe_busy) begin
                    w_en_d   = 1'b1;
                    w_addr_d = dst_q + ADDR_W'(wr_off) + ADDR_W'(col_q);
                    w_data_d = k_res;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (col_q != w_q - DIM_W'(1)) begin
                    col_d   = col_q + DIM_W'(1);
                    dx_d    = last;
                    dy_d    = '0;
                    state_d = S_SHIFT;
                end else if (row_q != h_q - DIM_W'(1)) begin
                    col_d   = '0;
                    row_d   = row_q + DIM_W'(1);
                    dx_d    = '0;
                    dy_d    = '0;
                    state_d = S_FILL;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs; read data aligned through a two-stage slot pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            h_q       <= '0;
            w_q       <= '0;
            n_q       <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            s1_v      <= 1'b0;
            s1_zero   <= 1'b0;
            s1_nl     <= 1'b0;
            s2_v      <= 1'b0;
            s2_zero   <= 1'b0;
            s2_nl     <= 1'b0;
            r_en      <= 1'b0;
            r_addr    <= '0;
            w_en      <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
            k_valid   <= 1'b0;
            k_pixel   <= '0;
            k_newline <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            w_q       <= w_d;
            n_q       <= n_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            row_q     <= row_d;
            col_q     <= col_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            s1_v      <= issue;
            s1_zero   <= issue & zero_px;
            s1_nl     <= first_px;
            s2_v      <= s1_v;
            s2_zero   <= s1_zero;
            s2_nl     <= s1_nl;
            r_en      <= issue & ~zero_px;
            if (issue && !zero_px) r_addr <= rd_addr;
            w_en      <= w_en_d;
            w_addr    <= w_addr_d;
            w_data    <= w_data_d;
            k_valid   <= s2_v;
            k_pixel   <= (s2_v && !s2_zero) ? r_data : '0;
            k_newline <= s2_nl;
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
            error     <= error_d;
        end
    end

endmodule

// File: tb/tb_wos_window_sequencer.sv
// Scoreboard bench for wos_window_sequencer: memory and kernel models, queued expectations checked by a monitor.
module tb_wos_window_sequencer;

    localparam int unsigned WORD   = 8;
    localparam int unsigned MAX_N  = 5;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DIM_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DIM_W-1:0]  h, w, n;
    logic [ADDR_W-1:0] src_base, dst_base;
    logic              r_en;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD-1:0]   r_data;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [WORD-1:0]   w_data;
    logic              k_valid;
    logic [WORD-1:0]   k_pixel;
    logic              k_newline;
    logic              k_res_valid;
    logic [WORD-1:0]   k_res;
    logic              busy, done, error;

    wos_window_sequencer #(.WORD(WORD), .MAX_N(MAX_N), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .h(h), .w(w), .n(n),
        .src_base(src_base), .dst_base(dst_base),
        .r_en(r_en), .r_addr(r_addr), .r_data(r_data),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .k_valid(k_valid), .k_pixel(k_pixel), .k_newline(k_newline),
        .k_res_valid(k_res_valid), .k_res(k_res),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WORD-1:0]   data;
    } wr_t;

    wr_t               exp_wr[$];
    logic [ADDR_W-1:0] exp_ra[$];
    logic [WORD-1:0]   exp_px[$];
    logic [WORD-1:0]   mem [0:65535];

    int errs = 0, checks = 0;
    int r_cnt = 0, w_cnt = 0, done_cnt = 0, kv_win = 0, kv_exp = 0;
    int first_fill_reads = 0, overlap = 0, unexp = 0, drain_strobes = 0;
    bit seen_write = 0;
    int tb_n = 3, kdel = 2, kmode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Synchronous memory: read data one cycle after r_en
    always @(posedge clk) begin
        if (r_en) r_data <= mem[r_addr];
        if (w_en) mem[w_addr] <= w_data;
    end

    // Monitor: pops expectations whenever the DUT presents a read, pixel or write
    initial begin
        forever begin
            @(negedge clk);
            if (r_en && w_en) overlap++;
            if (r_en) begin
                r_cnt++;
                if (!seen_write) first_fill_reads++;
                if (exp_ra.size() > 0) chk("read_addr", r_addr, exp_ra.pop_front());
            end
            if (k_valid) begin
                kv_win++;
                if (exp_px.size() > 0) chk("k_pixel", k_pixel, exp_px.pop_front());
            end
            if (w_en) begin
                wr_t e;
                w_cnt++;
                seen_write = 1;
                if (kv_exp > 0) chk("kvalid_per_window", kv_win, kv_exp);
                kv_win = 0;
                if (exp_wr.size() == 0) begin
                    unexp++;
                end else begin
                    e = exp_wr.pop_front();
                    chk("w_addr", w_addr, e.addr);
                    chk("w_data", w_data, e.data);
                end
            end
            if (done) done_cnt++;
        end
    end

    // Kernel model: max (or last pixel) of the sliding n*n buffer, answered kdel cycles after the window
    initial begin
        int kbuf[$];
        int kcnt, need, cd, res;
        bit pend;
        kcnt = 0; need = 0; cd = 0; res = 0; pend = 0;
        k_res_valid = 1'b0;
        k_res = '0;
        forever begin
            @(negedge clk);
            k_res_valid = 1'b0;
            if (rst) begin
                pend = 0;
                kcnt = 0;
                kbuf.delete();
            end else begin
                if (pend) begin
                    if (r_en || w_en) drain_strobes++;
                    if (cd <= 0) begin
                        k_res_valid = 1'b1;
                        k_res = WORD'(res);
                        pend = 0;
                    end else begin
                        cd--;
                    end
                end
                if (k_valid) begin
                    if (k_newline) begin
                        kbuf.delete();
                        kcnt = 0;
                        need = tb_n * tb_n;
                    end
                    kbuf.push_back(int'(k_pixel));
                    if (kbuf.size() > tb_n * tb_n) void'(kbuf.pop_front());
                    kcnt++;
                    if (kcnt == need) begin
                        kcnt = 0;
                        need = tb_n;
                        res = 0;
                        if (kmode == 1) res = int'(k_pixel);
                        else foreach (kbuf[i]) if (kbuf[i] > res) res = kbuf[i];
                        pend = 1;
                        cd = kdel - 1;
                    end
                end
            end
        end
    end

    task automatic start_op(input int hh, input int ww, input int nn, input int src, input int dst);
        @(negedge clk);
        h = DIM_W'(hh);
        w = DIM_W'(ww);
        n = DIM_W'(nn);
        src_base = ADDR_W'(src);
        dst_base = ADDR_W'(dst);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int i;
        i = 0;
        while (!done && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk(name, done, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_counts();
        r_cnt = 0; w_cnt = 0; done_cnt = 0; kv_win = 0;
        first_fill_reads = 0; seen_write = 0; drain_strobes = 0;
    endtask

    // 3x3 image of 10..90 at 0x000, max kernel, results to 0x100
    task automatic setup_basic();
        int wexp[9] = '{50, 60, 60, 80, 90, 90, 80, 90, 90};
`ifdef WOS_ZERO_BORDER_EN
        int ra[$] = '{0, 3, 1, 4};
        int px[$] = '{0, 0, 0, 0, 10, 40, 0, 20, 50};
`else
        int ra[$] = '{0, 0, 3, 0, 0, 3, 1, 1, 4};
        int px[$] = '{10, 10, 40, 10, 10, 40, 20, 20, 50};
`endif
        tb_n = 3; kmode = 0; kv_exp = 0;
        for (int i = 0; i < 9; i++) begin
            wr_t e;
            e.addr = ADDR_W'(16'h100 + i);
            e.data = WORD'(wexp[i]);
            exp_wr.push_back(e);
        end
        foreach (ra[i]) exp_ra.push_back(ADDR_W'(ra[i]));
        foreach (px[i]) exp_px.push_back(WORD'(px[i]));
    endtask

    initial begin
        int bad_n[3] = '{4, 7, 0};
        int i;
        rst = 1'b1; start = 1'b0; h = '0; w = '0; n = '0; src_base = '0; dst_base = '0;
        for (int a = 0; a < 65536; a++) mem[a] = '0;
        for (int a = 0; a < 9; a++) mem[a] = WORD'(10 * (a + 1));
        for (int a = 0; a < 8; a++) mem[16'h40 + a] = WORD'(17 * (a + 1));
        repeat (3) @(negedge clk);
        chk("reset_strobes", {r_en, w_en, k_valid, k_newline}, 0);
        chk("reset_status", {busy, done, error}, 0);
        chk("reset_addr", {r_addr, w_addr}, 0);
        rst = 1'b0;

        // Basic 3x3, n=3
        clear_counts();
        setup_basic();
        start_op(3, 3, 3, 0, 16'h100);
        chk("busy_after_start", busy, 1);
        wait_done(1000, "basic_done");
`ifdef WOS_ZERO_BORDER_EN
        chk("first_fill_reads", first_fill_reads, 4);
`else
        chk("first_fill_reads", first_fill_reads, 9);
        chk("total_reads", r_cnt, 45);
`endif
        chk("basic_writes", w_cnt, 9);
        chk("basic_done_pulses", done_cnt, 1);
        chk("basic_queue_empty", exp_wr.size(), 0);
        chk("basic_drain_strobes", drain_strobes, 0);
        chk("basic_idle", {busy, error}, 0);

        // n=1 identity: destination copies source
        clear_counts();
        tb_n = 1; kmode = 1; kv_exp = 1;
        for (int a = 0; a < 8; a++) begin
            wr_t e;
            e.addr = ADDR_W'(16'h300 + a);
            e.data = WORD'(17 * (a + 1));
            exp_wr.push_back(e);
        end
        start_op(2, 4, 1, 16'h40, 16'h300);
        wait_done(1000, "n1_done");
        chk("n1_reads", r_cnt, 8);
        chk("n1_writes", w_cnt, 8);
        chk("n1_queue_empty", exp_wr.size(), 0);
        kv_exp = 0;

        // Bad parameters: n=4, n=7, n=0
        for (int b = 0; b < 3; b++) begin
            clear_counts();
            start_op(3, 3, bad_n[b], 0, 16'h100);
            chk("bad_done_next_cycle", done, 1);
            chk("bad_error_set", error, 1);
            @(negedge clk);
            chk("bad_done_one_cycle", done, 0);
            repeat (4) @(negedge clk);
            chk("bad_no_reads", r_cnt, 0);
            chk("bad_error_sticky", error, 1);
        end
        clear_counts();
        setup_basic();
        start_op(3, 3, 3, 0, 16'h100);
        chk("error_cleared", error, 0);
        wait_done(1000, "after_bad_done");
        chk("after_bad_queue_empty", exp_wr.size(), 0);

        // Reset during SHIFT of window 5
        clear_counts();
        setup_basic();
        start_op(3, 3, 3, 0, 16'h100);
        i = 0;
        while (w_cnt < 4 && i < 500) begin @(negedge clk); i++; end
        chk("reached_window5", w_cnt, 4);
        i = 0;
        while (!r_en && i < 100) begin @(negedge clk); i++; end
        chk("shift_read_seen", r_en, 1);
        rst = 1'b1;
        #1;
        chk("midrst_strobes", {r_en, w_en, k_valid, k_newline}, 0);
        chk("midrst_status", {busy, done, error}, 0);
        chk("midrst_data", {r_addr, w_addr, w_data, k_pixel}, 0);
        exp_wr.delete(); exp_ra.delete(); exp_px.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_counts();
        setup_basic();
        start_op(3, 3, 3, 0, 16'h100);
        wait_done(1000, "post_reset_done");
        chk("post_reset_writes", w_cnt, 9);
        chk("post_reset_queue_empty", exp_wr.size(), 0);

        // Slow kernel plus a start pulse while busy
        clear_counts();
        kdel = 10;
        setup_basic();
        start_op(3, 3, 3, 0, 16'h100);
        repeat (20) @(negedge clk);
        start_op(3, 3, 4, 16'h500, 16'h600);
        wait_done(2000, "slow_done");
        chk("slow_writes", w_cnt, 9);
        chk("slow_queue_empty", exp_wr.size(), 0);
        chk("slow_drain_strobes", drain_strobes, 0);
        chk("slow_error_clear", error, 0);
        chk("slow_done_pulses", done_cnt, 1);

        chk("rw_overlap", overlap, 0);
        chk("unexpected_writes", unexp, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
